crossbar_pipelined: RTL and testbench
=====================================

Name: crossbar_pipelined

Overview:
Parametrised successor of the router switch crossbar. Maps P input flits to P outputs from one-hot switch-allocator grants, with optional self-loop and SSA write injection. Adds 0–2 registered output pipeline stages. Adds sticky per-output grant-conflict detection. Sits between the SA/VC-allocation stage and the router output ports, inside the router pipeline.

Parameters:
P, 5, router port count (≥2)
Fw, 36, flit width in bits
SELF_LOOP_EN, 0, 1: an input may be granted to its own output index
SSA_EN, 1, 1: ssa_flit_wr_all ORed into output write and selects the straight source when no grant exists
MUX_TYPE, "BINARY", "ONE_HOT" or "BINARY" data mux implementation
PIPE_STAGES, 1, registered output stages: 0, 1 or 2
CNT_W, 16, per-output flit counter width (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
granted_dest_port_all  in  P*P_1  per-input one-hot output grant; P_1 = SELF_LOOP_EN ? P : P-1
flit_in_all  in  P*Fw  input flits, input i at [i*Fw +: Fw]
ssa_flit_wr_all  in  P  SSA write request per output
err_clr  in  1  synchronous clear of conflict_err_all
flit_out_all  out  P*Fw  output flits
flit_out_wr_all  out  P  output write strobes
conflict_err_all  out  P  sticky: more than one input granted this output
flit_cnt_all  out  P*CNT_W  per-output flit counters (present only with CROSSBAR_FLIT_CNT_EN)
cnt_clr  in  1  synchronous counter clear (present only with CROSSBAR_FLIT_CNT_EN)

Behaviour:
- Grant mapping: bit k of input i's vector addresses output k.
  - SELF_LOOP_EN=1: mapping is always k.
  - SELF_LOOP_EN=0: k if k<i, else k+1.
- Combinational core, per output o:
  - sel_o = set of inputs granting o.
  - wr_o = |sel_o | (SSA_EN & ssa_flit_wr_all[o]).
  - Data = flit of the single selected input.
  - If sel_o is empty and SSA_EN: data = flit of ss_src(o) (package function).
  - If sel_o is empty and no SSA: data is don't-care, wr_o=0.
- Conflict (popcount(sel_o) > 1): data is unspecified; wr_o=1.
- PIPE_STAGES=0: outputs driven combinationally, zero latency.
- PIPE_STAGES=N>0: data and wr delayed exactly N cycles through a shift chain of registers. No stall, no back-pressure; credits upstream guarantee acceptance.
- Reset (async assert, sync-released by the system):
  - All pipeline wr bits, data registers, conflict_err_all and counters → 0.
  - In-flight flits are discarded.
  - The first cycle after reset release shows wr=0 on all outputs.
- conflict_err_all[o]:
  - Set on the clock edge following a conflict cycle, independent of PIPE_STAGES.
  - Cleared by err_clr; set wins over a simultaneous err_clr.
- Grants addressing an illegal output (self with SELF_LOOP_EN=0) cannot be expressed in the encoding. No check is required.

Optional Feature:
Macro CROSSBAR_FLIT_CNT_EN.
- Defined:
  - flit_cnt_all and cnt_clr exist.
  - Counter o increments on each cycle flit_out_wr_all[o]=1 (post-pipeline).
  - Saturates at 2^CNT_W-1.
  - cnt_clr forces 0; clear beats a simultaneous increment.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package crossbar_pkg holds:
  - p_1(P, SELF_LOOP_EN) width function and log2.
  - grant-bit-to-output mapping function.
  - ss_src(o, P) straight-port function. Mesh P=5: local 0 has none; 1↔3, 2↔4; any other P: none.
- One sub-module crossbar_out_pipe: parametrised N-stage data+wr register chain with async active-low reset, instantiated per output.

Test Plan:
- PIPE_STAGES=1, P=5, SELF_LOOP_EN=0.
  - Stimulus: input0 grant [3:0]=4'b0001, flit_in0=36'h0_AAAA_0001; input2 grant [11:8]=4'b0001, flit_in2=36'h0_BBBB_0002.
  - Response: next cycle out1=36'h0_AAAA_0001, out0=36'h0_BBBB_0002, flit_out_wr_all=5'b00011.
- SSA: no grants, ssa_flit_wr_all=5'b00010, flit_in3=36'h0_CCCC_0003 → after 1 cycle out1=36'h0_CCCC_0003, wr=5'b00010.
- Conflict: input0 and input2 both grant output 1 for one cycle → wr[1]=1 after 1 cycle; conflict_err_all=5'b00010 from the next edge and held. Then err_clr pulse → 0; err_clr together with a new conflict → stays 1.
- PIPE_STAGES=2: back-to-back flits 1,2,3 on input0→output1 appear on out1 exactly 2 cycles later, consecutive. Assert reset mid-stream → wr=0 immediately and all in-flight flits lost.
- SELF_LOOP_EN=1, PIPE_STAGES=0: input3 grant bit3 → out3=flit_in3 in the same cycle.
- With CROSSBAR_FLIT_CNT_EN, CNT_W=4: 20 writes to output2 → flit_cnt=15 (saturated); cnt_clr together with a write → 0.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared sizing and port-mapping helpers for the pipelined router crossbar.
package crossbar_pkg;

    function automatic int p_1(input int p, input int self_loop_en);
        return (self_loop_en != 0) ? p : p - 1;
    endfunction

    // Ceiling log2, never below 1 so index vectors always have at least one bit.
    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Output addressed by grant bit k of input i; without self-loop the own port is skipped.
    function automatic int grant_to_out(input int i, input int k, input int self_loop_en);
        return (self_loop_en != 0 || k < i) ? k : k + 1;
    endfunction

    // Straight-through source of output o in a 5-port mesh; -1 where none exists.
    function automatic int ss_src(input int o, input int p);
        if (p != 5) return -1;
        case (o)
            1:       return 3;
            3:       return 1;
            2:       return 4;
            4:       return 2;
            default: return -1;
        endcase
    endfunction

endpackage

// File: rtl/crossbar_out_pipe.sv
// N-stage data + write-strobe register chain for one crossbar output (N=0 is a wire).
module crossbar_out_pipe #(
    parameter int N = 1,
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_data,
    input  logic         i_wr,
    output logic [W-1:0] o_data,
    output logic         o_wr
);

    if (N == 0) begin : g_bypass
        logic w_unused_clk;
        assign w_unused_clk = clk ^ rst_n;
        assign o_data       = i_data;
        assign o_wr         = i_wr;
    end else begin : g_chain
        logic [W-1:0] r_data [N];
        logic         r_wr   [N];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: payload registers are reset too, so nothing stale survives a reset.
                for (int s = 0; s < N; s++) begin
                    r_data[s] <= '0;
                    r_wr[s]   <= 1'b0;
                end
            end else begin
                // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
                r_data[0] <= i_data;
                r_wr[0]   <= i_wr;
                for (int s = 1; s < N; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_wr[s]   <= r_wr[s-1];
                end
            end
        end

        assign o_data = r_data[N-1];
        assign o_wr   = r_wr[N-1];
    end

endmodule

// File: rtl/crossbar_pipelined.sv
// P x P router crossbar with 0-2 output register stages and sticky conflict flags.
// Optional per-output flit counters are enabled by defining CROSSBAR_FLIT_CNT_EN.
module crossbar_pipelined
    import crossbar_pkg::*;
#(
    parameter int    P            = 5,
    parameter int    Fw           = 36,
    parameter int    SELF_LOOP_EN = 0,
    parameter int    SSA_EN       = 1,
    parameter string MUX_TYPE     = "BINARY",
    parameter int    PIPE_STAGES  = 1,
    parameter int    CNT_W        = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [P*p_1(P, SELF_LOOP_EN)-1:0]    granted_dest_port_all,
    input  logic [P*Fw-1:0]                      flit_in_all,
    input  logic [P-1:0]                         ssa_flit_wr_all,
    input  logic                                 err_clr,
    output logic [P*Fw-1:0]                      flit_out_all,
    output logic [P-1:0]                         flit_out_wr_all,
    output logic [P-1:0]                         conflict_err_all
`ifdef CROSSBAR_FLIT_CNT_EN
    ,
    output logic [P*CNT_W-1:0]                   flit_cnt_all,
    input  logic                                 cnt_clr
`endif
);

    localparam int   P_1    = p_1(P, SELF_LOOP_EN);
    localparam int   IDX_W  = log2(P);
    localparam logic SSA_ON = (SSA_EN != 0);

    logic [P-1:0] w_wr;
    logic [P-1:0] w_conflict;
    logic [P-1:0] w_out_wr;
    logic [P-1:0] r_conflict_err;

    for (genvar o = 0; o < P; o++) begin : g_out
        localparam int SS = ss_src(o, P);
        logic [P-1:0]  w_sel;
        logic [Fw-1:0] w_mux;
        logic [Fw-1:0] w_data;

        always_comb begin
            // NOTE: default first, so the conditional set below never infers a latch.
            w_sel = '0;
            for (int i = 0; i < P; i++)
                for (int k = 0; k < P_1; k++)
                    if (grant_to_out(i, k, SELF_LOOP_EN) == o && granted_dest_port_all[i*P_1 + k])
                        w_sel[i] = 1'b1;
        end

        if (MUX_TYPE == "ONE_HOT") begin : g_one_hot
            always_comb begin
                w_mux = '0;
                for (int i = 0; i < P; i++)
                    w_mux = w_mux | ({Fw{w_sel[i]}} & flit_in_all[i*Fw +: Fw]);
            end
        end else begin : g_binary
            logic [IDX_W-1:0] w_idx;
            always_comb begin
                w_idx = '0;
                for (int i = 0; i < P; i++)
                    if (w_sel[i]) w_idx = IDX_W'(i);
            end
            assign w_mux = flit_in_all[w_idx*Fw +: Fw];
        end

        // Ungranted outputs forward the straight-through port so SSA writes carry its flit.
        if (SSA_EN != 0 && SS >= 0) begin : g_ssa_src
            assign w_data = (w_sel == '0) ? flit_in_all[SS*Fw +: Fw] : w_mux;
        end else begin : g_no_ssa_src
            assign w_data = w_mux;
        end

        assign w_wr[o]       = (|w_sel) | (SSA_ON & ssa_flit_wr_all[o]);
        assign w_conflict[o] = ($countones(w_sel) > 1);

        crossbar_out_pipe #(
            .N (PIPE_STAGES),
            .W (Fw)
        ) u_pipe (
            .clk    (clk),
            .rst_n  (reset),
            .i_data (w_data),
            .i_wr   (w_wr[o]),
            .o_data (flit_out_all[o*Fw +: Fw]),
            .o_wr   (w_out_wr[o])
        );
    end

    // Conflicts are flagged from the unpipelined core; a new conflict beats err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_conflict_err <= '0;
        else        r_conflict_err <= w_conflict | (r_conflict_err & ~{P{err_clr}});
    end

    assign conflict_err_all = r_conflict_err;
    assign flit_out_wr_all  = w_out_wr;

`ifdef CROSSBAR_FLIT_CNT_EN
    logic [CNT_W-1:0] r_cnt [P];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < P; o++) r_cnt[o] <= '0;
        end else begin
            for (int o = 0; o < P; o++) begin
                if (cnt_clr)                             r_cnt[o] <= '0;
                else if (w_out_wr[o] && r_cnt[o] != '1)  r_cnt[o] <= r_cnt[o] + CNT_W'(1);
            end
        end
    end

    for (genvar o = 0; o < P; o++) begin : g_cnt_out
        assign flit_cnt_all[o*CNT_W +: CNT_W] = r_cnt[o];
    end
`else
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_crossbar_pipelined.sv
// Randomized + directed bench for crossbar_pipelined against a behavioural port-mapping model.
module tb_crossbar_pipelined;

    localparam int P  = 5;
    localparam int FW = 36;
    localparam int CW = 4;

    typedef struct packed {
        logic [P-1:0]         wr;
        logic [P-1:0]         known;
        logic [P-1:0]         conf;
        logic [P-1:0][FW-1:0] data;
    } res_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [P*(P-1)-1:0] grant_a;
    logic [P*P-1:0]     grant_b, grant_c;
    logic [P*FW-1:0]    flit_in;
    logic [P-1:0]       ssa_wr;
    logic               err_clr;
    logic [P*FW-1:0]    out_a, out_b, out_c;
    logic [P-1:0]       wr_a, wr_b, wr_c;
    logic [P-1:0]       err_a, err_b, err_c;
`ifdef CROSSBAR_FLIT_CNT_EN
    logic               cnt_clr;
    logic [P*CW-1:0]    cnt_a, cnt_b, cnt_c;
    int                 cnt_m [3][P];
`endif

    int   n_cmp, n_bad;
    int   straight [P] = '{-1, 3, 4, 1, 2};
    res_t pipe_a, pipe_b0, pipe_b1;
    logic [P-1:0] err_m [3];

    always #5 clk = ~clk;

    crossbar_pipelined #(.P(P), .Fw(FW), .SELF_LOOP_EN(0), .SSA_EN(1), .MUX_TYPE("BINARY"),
                         .PIPE_STAGES(1), .CNT_W(CW)) u_a (
        .clk(clk), .reset(reset), .granted_dest_port_all(grant_a), .flit_in_all(flit_in),
        .ssa_flit_wr_all(ssa_wr), .err_clr(err_clr), .flit_out_all(out_a),
        .flit_out_wr_all(wr_a), .conflict_err_all(err_a)
`ifdef CROSSBAR_FLIT_CNT_EN
        , .flit_cnt_all(cnt_a), .cnt_clr(cnt_clr)
`endif
    );

    crossbar_pipelined #(.P(P), .Fw(FW), .SELF_LOOP_EN(1), .SSA_EN(1), .MUX_TYPE("ONE_HOT"),
                         .PIPE_STAGES(2), .CNT_W(CW)) u_b (
        .clk(clk), .reset(reset), .granted_dest_port_all(grant_b), .flit_in_all(flit_in),
        .ssa_flit_wr_all(ssa_wr), .err_clr(err_clr), .flit_out_all(out_b),
        .flit_out_wr_all(wr_b), .conflict_err_all(err_b)
`ifdef CROSSBAR_FLIT_CNT_EN
        , .flit_cnt_all(cnt_b), .cnt_clr(cnt_clr)
`endif
    );

    crossbar_pipelined #(.P(P), .Fw(FW), .SELF_LOOP_EN(1), .SSA_EN(0), .MUX_TYPE("BINARY"),
                         .PIPE_STAGES(0), .CNT_W(CW)) u_c (
        .clk(clk), .reset(reset), .granted_dest_port_all(grant_c), .flit_in_all(flit_in),
        .ssa_flit_wr_all(ssa_wr), .err_clr(err_clr), .flit_out_all(out_c),
        .flit_out_wr_all(wr_c), .conflict_err_all(err_c)
`ifdef CROSSBAR_FLIT_CNT_EN
        , .flit_cnt_all(cnt_c), .cnt_clr(cnt_clr)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count grants per output from the port-mapping rule, then decide write/data per output.
    function automatic res_t ref_model(input logic [P*P-1:0] g, input int pw, input bit self_loop,
                                       input bit ssa_en, input logic [P*FW-1:0] fin,
                                       input logic [P-1:0] ssa);
        res_t r;
        int   hits [P];
        int   src  [P];
        r = '0;
        for (int o = 0; o < P; o++) begin
            hits[o] = 0;
            src[o]  = 0;
        end
        for (int i = 0; i < P; i++)
            for (int k = 0; k < pw; k++)
                if (g[i*pw + k]) begin
                    int d;
                    d = (self_loop || k < i) ? k : k + 1;
                    hits[d]++;
                    src[d] = i;
                end
        for (int o = 0; o < P; o++) begin
            r.conf[o] = (hits[o] > 1);
            r.wr[o]   = (hits[o] > 0) || (ssa_en && ssa[o]);
            if (hits[o] == 1) begin
                r.data[o]  = fin[src[o]*FW +: FW];
                r.known[o] = 1'b1;
            end else if (hits[o] == 0 && ssa_en && straight[o] >= 0) begin
                r.data[o]  = fin[straight[o]*FW +: FW];
                r.known[o] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [P*P-1:0] rand_grant(input int pw);
        logic [P*P-1:0] g;
        g = '0;
        for (int i = 0; i < P; i++)
            if ($urandom_range(0, 1) == 1) g[i*pw + $urandom_range(0, pw - 1)] = 1'b1;
        return g;
    endfunction

`ifdef CROSSBAR_FLIT_CNT_EN
    function automatic int sat_step(input int c, input bit wr, input bit clr);
        if (clr) return 0;
        if (wr && c < (1 << CW) - 1) return c + 1;
        return c;
    endfunction
`endif

    task automatic model_reset();
        pipe_a  = '0;
        pipe_b0 = '0;
        pipe_b1 = '0;
        for (int d = 0; d < 3; d++) err_m[d] = '0;
`ifdef CROSSBAR_FLIT_CNT_EN
        for (int d = 0; d < 3; d++)
            for (int o = 0; o < P; o++) cnt_m[d][o] = 0;
`endif
    endtask

    task automatic check_res(input string tag, input logic [P-1:0] wr,
                             input logic [P*FW-1:0] dat, input res_t e);
        check({tag, "_wr"}, 64'(wr), 64'(e.wr));
        for (int o = 0; o < P; o++)
            if (e.wr[o] && e.known[o] && !e.conf[o])
                check($sformatf("%s_data%0d", tag, o), 64'(dat[o*FW +: FW]), 64'(e.data[o]));
    endtask

    // Check all DUTs at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        res_t ca, cb, cc;
        @(negedge clk);
        ca = ref_model({{P{1'b0}}, grant_a}, P - 1, 1'b0, 1'b1, flit_in, ssa_wr);
        cb = ref_model(grant_b, P, 1'b1, 1'b1, flit_in, ssa_wr);
        cc = ref_model(grant_c, P, 1'b1, 1'b0, flit_in, ssa_wr);
        check_res("a", wr_a, out_a, pipe_a);
        check_res("b", wr_b, out_b, pipe_b1);
        check_res("c", wr_c, out_c, cc);
        check("a_err", 64'(err_a), 64'(err_m[0]));
        check("b_err", 64'(err_b), 64'(err_m[1]));
        check("c_err", 64'(err_c), 64'(err_m[2]));
`ifdef CROSSBAR_FLIT_CNT_EN
        for (int o = 0; o < P; o++) begin
            check($sformatf("a_cnt%0d", o), 64'(cnt_a[o*CW +: CW]), 64'(cnt_m[0][o]));
            check($sformatf("b_cnt%0d", o), 64'(cnt_b[o*CW +: CW]), 64'(cnt_m[1][o]));
            check($sformatf("c_cnt%0d", o), 64'(cnt_c[o*CW +: CW]), 64'(cnt_m[2][o]));
        end
`endif
        @(posedge clk);
        if (reset) begin
            err_m[0] = ca.conf | (err_m[0] & ~{P{err_clr}});
            err_m[1] = cb.conf | (err_m[1] & ~{P{err_clr}});
            err_m[2] = cc.conf | (err_m[2] & ~{P{err_clr}});
`ifdef CROSSBAR_FLIT_CNT_EN
            for (int o = 0; o < P; o++) begin
                cnt_m[0][o] = sat_step(cnt_m[0][o], pipe_a.wr[o], cnt_clr);
                cnt_m[1][o] = sat_step(cnt_m[1][o], pipe_b1.wr[o], cnt_clr);
                cnt_m[2][o] = sat_step(cnt_m[2][o], cc.wr[o], cnt_clr);
            end
`endif
            pipe_b1 = pipe_b0;
            pipe_b0 = cb;
            pipe_a  = ca;
        end
        #1;
    endtask

    initial begin
        logic [P*P-1:0] g;
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        grant_a = '0;
        grant_b = '0;
        grant_c = '0;
        flit_in = '0;
        ssa_wr  = '0;
        err_clr = 1'b0;
`ifdef CROSSBAR_FLIT_CNT_EN
        cnt_clr = 1'b0;
`endif
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        check("rel_wr_a", 64'(wr_a), 64'(0));
        check("rel_wr_b", 64'(wr_b), 64'(0));
        tick();

        // Two independent grants through the 1-stage crossbar.
        flit_in[0*FW +: FW] = 36'h0_AAAA_0001;
        flit_in[2*FW +: FW] = 36'h0_BBBB_0002;
        grant_a[3:0]  = 4'b0001;
        grant_a[11:8] = 4'b0001;
        tick();
        grant_a = '0;
        check("t1_out1", 64'(out_a[1*FW +: FW]), 64'(36'h0_AAAA_0001));
        check("t1_out0", 64'(out_a[0*FW +: FW]), 64'(36'h0_BBBB_0002));
        check("t1_wr",   64'(wr_a), 64'(5'b00011));

        // SSA write with no grant takes the straight-through input.
        flit_in = '0;
        flit_in[3*FW +: FW] = 36'h0_CCCC_0003;
        ssa_wr = 5'b00010;
        tick();
        ssa_wr = '0;
        check("t2_out1", 64'(out_a[1*FW +: FW]), 64'(36'h0_CCCC_0003));
        check("t2_wr",   64'(wr_a), 64'(5'b00010));

        // Conflict: sticky flag, clear, and set winning over clear.
        grant_a[3:0]  = 4'b0001;
        grant_a[11:8] = 4'b0010;
        tick();
        grant_a = '0;
        check("t3_wr1",  64'(wr_a[1]), 64'(1));
        check("t3_err",  64'(err_a), 64'(5'b00010));
        tick();
        check("t3_hold", 64'(err_a), 64'(5'b00010));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_clr",  64'(err_a), 64'(0));
        err_clr = 1'b1;
        grant_a[3:0]  = 4'b0001;
        grant_a[11:8] = 4'b0010;
        tick();
        err_clr = 1'b0;
        grant_a = '0;
        check("t3_set_wins", 64'(err_a), 64'(5'b00010));

        // Two-stage chain: back-to-back flits 1,2,3 on input0 -> output1.
        grant_b[4:0] = 5'b00010;
        flit_in[0*FW +: FW] = 36'd1;
        tick();
        flit_in[0*FW +: FW] = 36'd2;
        tick();
        check("t4_f1", 64'(out_b[1*FW +: FW]), 64'(1));
        check("t4_w1", 64'(wr_b), 64'(5'b00010));
        flit_in[0*FW +: FW] = 36'd3;
        tick();
        check("t4_f2", 64'(out_b[1*FW +: FW]), 64'(2));
        grant_b = '0;
        tick();
        check("t4_f3", 64'(out_b[1*FW +: FW]), 64'(3));
        tick();
        check("t4_idle", 64'(wr_b), 64'(0));

        // Reset in mid-stream drops everything in flight.
        grant_b[4:0] = 5'b00010;
        flit_in[0*FW +: FW] = 36'd4;
        tick();
        flit_in[0*FW +: FW] = 36'd5;
        tick();
        check("t4_pre_rst", 64'(wr_b), 64'(5'b00010));
        reset = 1'b0;
        model_reset();
        #1;
        check("t4_rst_wr_b", 64'(wr_b), 64'(0));
        check("t4_rst_err",  64'(err_a), 64'(0));
        grant_b = '0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("t4_lost", 64'(wr_b), 64'(0));

        // Self-loop, zero-latency instance.
        grant_c[3*P + 3] = 1'b1;
        flit_in[3*FW +: FW] = 36'h0_DDDD_0003;
        #1;
        check("t5_out3", 64'(out_c[3*FW +: FW]), 64'(36'h0_DDDD_0003));
        check("t5_wr",   64'(wr_c), 64'(5'b01000));
        tick();
        grant_c = '0;

`ifdef CROSSBAR_FLIT_CNT_EN
        // Counter saturation and clear-over-increment on output2.
        grant_a[3:0] = 4'b0010;
        repeat (20) tick();
        check("t6_sat", 64'(cnt_a[2*CW +: CW]), 64'(15));
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        grant_a = '0;
        check("t6_clr", 64'(cnt_a[2*CW +: CW]), 64'(0));
`endif

        for (int c = 0; c < 400; c++) begin
            g       = rand_grant(P - 1);
            grant_a = g[P*(P-1)-1:0];
            grant_b = rand_grant(P);
            grant_c = rand_grant(P);
            for (int i = 0; i < P; i++)
                flit_in[i*FW +: FW] = FW'({$urandom(), $urandom()});
            ssa_wr  = P'($urandom());
            err_clr = ($urandom_range(0, 9) == 0);
`ifdef CROSSBAR_FLIT_CNT_EN
            cnt_clr = ($urandom_range(0, 19) == 0);
`endif
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
